// File: rtl/run_pattern_gen_pkg.sv
// ---------------------------------------------------------------------------
// run_gen_pkg
// Shared types and constants for the run pattern generator and for anything
// that models the consecutive-ones detector (for example a scoreboard).
//   state_t        generator FSM states
//   PH0..PH3       detector phase encoding, number of trailing ones mod 3,
//                  with PH3 meaning "q is high this cycle"
//   GAP_MIN/MAX    legal range of the inter-run gap length
//   GAP_CNT_W      width of the gap counter, sized for GAP_MAX
// ---------------------------------------------------------------------------
package run_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] PH0 = 2'b00;
    localparam logic [1:0] PH1 = 2'b01;
    localparam logic [1:0] PH2 = 2'b10;
    localparam logic [1:0] PH3 = 2'b11;

    localparam int GAP_MIN   = 1;
    localparam int GAP_MAX   = 15;
    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/run_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// run_pattern_gen_if
// Request handshake carrying run lengths into the generator.
//   req_valid  requester has a run length to send
//   req_len    number of consecutive ones, 0 allowed
//   req_ready  generator accepts on this cycle's rising edge
// master = requester side, slave = generator side.
// ---------------------------------------------------------------------------
interface run_pattern_gen_if #(
    parameter int LEN_W = 4
);
    logic             req_valid;
    logic [LEN_W-1:0] req_len;
    logic             req_ready;

    modport master (output req_valid, output req_len, input req_ready);
    modport slave  (input req_valid, input req_len, output req_ready);
endinterface

// File: rtl/run_pattern_gen_phase.sv
// ---------------------------------------------------------------------------
// run_phase_model
// Mirror of the consecutive-ones detector: a 2-bit phase that follows the
// serial bit stream, and the predicted detector output derived from it.
//   clk      rising-edge clock
//   arstn    asynchronous active-low reset, clears the phase to PH0
//   w_i      serial bit currently on the line
//   exp_q_o  predicted detector q for the current cycle
// ---------------------------------------------------------------------------
module run_phase_model
    import run_gen_pkg::*;
(
    input  logic clk,
    input  logic arstn,
    input  logic w_i,
    output logic exp_q_o
);

    logic [1:0] phase_q, phase_d;

    // A one advances the phase; after the third one it wraps to PH1 rather
    // than PH0, so the fourth one already counts toward the next triple.
    always_comb begin
        phase_d = PH0;
        if (w_i) begin
            unique case (phase_q)
                PH0:     phase_d = PH1;
                PH1:     phase_d = PH2;
                PH2:     phase_d = PH3;
                default: phase_d = PH1;
            endcase
        end
    end

    // Phase register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            phase_q <= PH0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign exp_q_o = (phase_q == PH3);

endmodule

// File: rtl/run_pattern_gen.sv
// ---------------------------------------------------------------------------
// run_pattern_gen
// Serialises run-length requests as N ones followed by GAP zeros on w_out.
// It also predicts the consecutive-ones detector output (exp_q) so that a
// generator/detector pair can check itself.
//   clk, arstn  clock; asynchronous active-low reset
//   req         slave side of run_pattern_gen_if (valid/len/ready)
//   w_out       serial bit to the detector
//   w_valid     w_out carries run or gap bits
//   busy        FSM not idle
//   done        pulse during the final gap bit of each request
//   exp_q       predicted detector q
// Optional build macro RUN_PATTERN_GEN_STATS_EN adds two saturating 16-bit
// counters: runs_sent (done pulses) and q_hits (cycles with exp_q high).
// ---------------------------------------------------------------------------
module run_pattern_gen
    import run_gen_pkg::*;
#(
    parameter int LEN_W = 4,
    parameter int GAP   = 1
) (
    input  logic               clk,
    input  logic               arstn,
    run_pattern_gen_if.slave   req,
    output logic               w_out,
    output logic               w_valid,
    output logic               busy,
    output logic               done,
    output logic               exp_q
`ifdef RUN_PATTERN_GEN_STATS_EN
    ,
    output logic [15:0]        runs_sent,
    output logic [15:0]        q_hits
`endif
);

    if (GAP < GAP_MIN || GAP > GAP_MAX) begin : g_bad_gap
        $error("run_pattern_gen: GAP must be within 1..15");
    end

    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP - 1);

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     run_cnt_q, run_cnt_d;
    logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic                 w_out_q, w_valid_q;
    logic                 last_gap;
    logic                 accept;

    // Ready during the last gap bit as well, so back-to-back runs are
    // separated by exactly GAP zeros.
    assign last_gap      = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);
    assign req.req_ready = (state_q == ST_IDLE) || last_gap;
    assign accept        = req.req_valid && req.req_ready;

    // Next-state and counter logic. A zero-length request skips RUN and
    // goes straight to the gap.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    gap_cnt_d = '0;
                    run_cnt_d = req.req_len;
                    state_d   = (req.req_len != '0) ? ST_RUN : ST_GAP;
                end
            end
            ST_RUN: begin
                if (run_cnt_q == LEN_W'(1)) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end else begin
                    run_cnt_d = run_cnt_q - LEN_W'(1);
                end
            end
            ST_GAP: begin
                if (last_gap) begin
                    gap_cnt_d = '0;
                    if (accept) begin
                        run_cnt_d = req.req_len;
                        state_d   = (req.req_len != '0) ? ST_RUN : ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered line outputs. The outputs are taken
    // from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= ST_IDLE;
            run_cnt_q <= '0;
            gap_cnt_q <= '0;
            w_out_q   <= 1'b0;
            w_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            w_out_q   <= (state_d == ST_RUN);
            w_valid_q <= (state_d != ST_IDLE);
        end
    end

    assign w_out   = w_out_q;
    assign w_valid = w_valid_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = last_gap;

    run_phase_model u_phase (
        .clk     (clk),
        .arstn   (arstn),
        .w_i     (w_out_q),
        .exp_q_o (exp_q)
    );

`ifdef RUN_PATTERN_GEN_STATS_EN
    logic [15:0] runs_sent_q, q_hits_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            runs_sent_q <= '0;
            q_hits_q    <= '0;
        end else begin
            if (last_gap && runs_sent_q != 16'hFFFF) begin
                runs_sent_q <= runs_sent_q + 16'd1;
            end
            if (exp_q && q_hits_q != 16'hFFFF) begin
                q_hits_q <= q_hits_q + 16'd1;
            end
        end
    end

    assign runs_sent = runs_sent_q;
    assign q_hits    = q_hits_q;
`endif

endmodule
